// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for regfile_wb_arbiter: pipeline WB, MDU handshake, RF write port and ID queries.
// Build option REGARB_PERF_EN adds the two performance counter outputs.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_wb_reg_write;
  logic [4:0]    pipe_wb_rd;
  logic [63:0]   pipe_wb_data;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [4:0]    mdu_rd;
  logic [63:0]   mdu_data;
  logic          rf_reg_write;
  logic [4:0]    rf_rd;
  logic [63:0]   rf_data;
  logic          pipe_stall;
  logic [4:0]    q_ra1;
  logic [4:0]    q_ra2;
  logic          q_hit1;
  logic          q_hit2;
  logic [CW-1:0] fifo_count;
`ifdef REGARB_PERF_EN
  logic [31:0]   perf_conflict_cycles;
  logic [31:0]   perf_stall_cycles;
`endif

  modport master (
    output pipe_wb_reg_write, pipe_wb_rd, pipe_wb_data,
    output mdu_valid, mdu_rd, mdu_data, q_ra1, q_ra2,
`ifdef REGARB_PERF_EN
    input  perf_conflict_cycles, perf_stall_cycles,
`endif
    input  mdu_ready, rf_reg_write, rf_rd, rf_data, pipe_stall,
    input  q_hit1, q_hit2, fifo_count
  );

  modport slave (
    input  pipe_wb_reg_write, pipe_wb_rd, pipe_wb_data,
    input  mdu_valid, mdu_rd, mdu_data, q_ra1, q_ra2,
`ifdef REGARB_PERF_EN
    output perf_conflict_cycles, perf_stall_cycles,
`endif
    output mdu_ready, rf_reg_write, rf_rd, rf_data, pipe_stall,
    output q_hit1, q_hit2, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline WB and a FIFO of buffered MDU results.
// Build option REGARB_PERF_EN adds conflict/stall cycle counters.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [4:0]    rd_mem_r   [DEPTH];
  logic [63:0]   data_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [WW-1:0] wait_r;

  logic nonempty_s;
  logic stall_s;
  logic pipe_eff_s;
  logic pop_s;
  logic accept_s;
  logic push_s;
  logic hit1_s;
  logic hit2_s;

  assign nonempty_s = (count_r != CW'(0));
  assign stall_s    = (wait_r == WW'(MAX_WAIT)) && nonempty_s;
  // Gating with rst_n keeps the write port quiet while reset is held.
  assign pipe_eff_s = rst_n && bus.pipe_wb_reg_write && (bus.pipe_wb_rd != 5'd0) && !stall_s;
  assign pop_s      = rst_n && nonempty_s && !pipe_eff_s;
  assign accept_s   = bus.mdu_valid && bus.mdu_ready;
  assign push_s     = accept_s && (bus.mdu_rd != 5'd0);

  assign bus.mdu_ready  = (count_r != CW'(DEPTH));
  assign bus.pipe_stall = stall_s;
  assign bus.fifo_count = count_r;
  assign bus.q_hit1     = hit1_s;
  assign bus.q_hit2     = hit2_s;

  // Write-port mux: pipeline first, then FIFO head, else idle.
  always_comb begin
    bus.rf_reg_write = 1'b0;
    bus.rf_rd        = 5'd0;
    bus.rf_data      = 64'd0;
    if (pipe_eff_s) begin
      bus.rf_reg_write = 1'b1;
      bus.rf_rd        = bus.pipe_wb_rd;
      bus.rf_data      = bus.pipe_wb_data;
    end else if (pop_s) begin
      bus.rf_reg_write = 1'b1;
      bus.rf_rd        = rd_mem_r[rd_ptr_r];
      bus.rf_data      = data_mem_r[rd_ptr_r];
    end else begin
      bus.rf_reg_write = 1'b0;
      bus.rf_rd        = 5'd0;
      bus.rf_data      = 64'd0;
    end
  end

  // Query match over occupied slots; the head being popped still counts.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1_s = hit1_s | (({1'b0, AW'(AW'(i) - rd_ptr_r)} < count_r) &&
                         (rd_mem_r[i] == bus.q_ra1) && (bus.q_ra1 != 5'd0));
      hit2_s = hit2_s | (({1'b0, AW'(AW'(i) - rd_ptr_r)} < count_r) &&
                         (rd_mem_r[i] == bus.q_ra2) && (bus.q_ra2 != 5'd0));
    end
  end

  // FIFO storage, pointers, occupancy and head starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      wait_r   <= WW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= 5'd0;
        data_mem_r[i] <= 64'd0;
      end
    end else begin
      if (push_s) begin
        rd_mem_r[wr_ptr_r]   <= bus.mdu_rd;
        data_mem_r[wr_ptr_r] <= bus.mdu_data;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (!nonempty_s || pop_s) begin
        wait_r <= WW'(0);
      end else if (wait_r != WW'(MAX_WAIT)) begin
        wait_r <= wait_r + WW'(1);
      end else begin
        wait_r <= wait_r;
      end
    end
  end

`ifdef REGARB_PERF_EN
  logic [31:0] perf_conflict_r;
  logic [31:0] perf_stall_r;

  assign bus.perf_conflict_cycles = perf_conflict_r;
  assign bus.perf_stall_cycles    = perf_stall_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_r <= 32'd0;
      perf_stall_r    <= 32'd0;
    end else begin
      perf_conflict_r <= (nonempty_s && pipe_eff_s) ? perf_conflict_r + 32'd1 : perf_conflict_r;
      perf_stall_r    <= stall_s ? perf_stall_r + 32'd1 : perf_stall_r;
    end
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline WB stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained on cycles where the pipeline does not write. A starvation counter forces a pipeline bubble if the buffered MDU results wait too long. Query ports let the ID stage detect reads of registers with pending buffered writes.

Parameters:
DEPTH, 2, MDU result FIFO entries; power of two, >=2
MAX_WAIT, 4, cycles the FIFO head may wait before pipe_stall is raised; >=1

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  reset, asynchronous, active-low
pipe_wb_reg_write  input  1  pipeline WB write request
pipe_wb_rd  input  5  pipeline WB destination
pipe_wb_data  input  64  pipeline WB data
mdu_valid  input  1  MDU result valid
mdu_ready  output  1  FIFO can accept an MDU result
mdu_rd  input  5  MDU destination
mdu_data  input  64  MDU result
rf_reg_write  output  1  register-file write enable
rf_rd  output  5  register-file write address
rf_data  output  64  register-file write data
pipe_stall  output  1  pipeline must suppress its WB write and freeze this cycle
q_ra1  input  5  ID read address 1
q_ra2  input  5  ID read address 2
q_hit1  output  1  q_ra1 nonzero and matches a buffered entry
q_hit2  output  1  q_ra2 nonzero and matches a buffered entry
fifo_count  output  $clog2(DEPTH)+1  buffered entries

Behaviour:
- Reset (rst_n low, asynchronous): FIFO flushed (pointers and count 0), wait counter 0. All outputs deassert: rf_* 0, pipe_stall 0, q_hit* 0, fifo_count 0, mdu_ready 1 after reset.
- The same applies if reset arrives mid-operation. Buffered results are lost, and the MDU handshake restarts.
- mdu_ready = (count != DEPTH), derived from registered count only. A full FIFO does not accept in a cycle where it also drains.
- Accept = mdu_valid && mdu_ready. An accepted entry with mdu_rd == 0 completes the handshake but is discarded, not enqueued.
- Accepted results are never written in their accept cycle. Earliest write is the next cycle.
- pipe_eff = pipe_wb_reg_write && pipe_wb_rd != 0 && !pipe_stall.
- Combinational write-port mux, priority order:
  - pipe_eff: rf_* = pipe values.
  - else if count != 0: rf_* = FIFO head, and the head is popped at posedge.
  - else: rf_reg_write = 0, rf_rd = 0, rf_data = 0.
- Wait counter: 0 when the FIFO is empty or the head drains this cycle. Otherwise it increments each cycle the head is blocked, saturating at MAX_WAIT.
- pipe_stall = (wait counter == MAX_WAIT) && count != 0. It is combinational from registered state, so it is valid early in the cycle.
- While pipe_stall is high, the pipe request is ignored, so the head always drains. The pipeline gates its WB write with !pipe_stall and holds WB and all earlier stages.
- Simultaneous enqueue and pop: count unchanged, pointers wrap modulo DEPTH.
- q_hit*: the query address is compared against all valid entries. Entries popped this cycle still count as hits (conservative). Incoming mdu_* in the same cycle is not checked; that hazard belongs to the MDU in-flight scoreboard.
- WAW ordering between MDU and pipeline: the ID stage stalls any instruction whose rd or rs hits q_hit*. That stall is enforced outside this block.

Optional Feature:
Macro REGARB_PERF_EN.
- Defined: adds a 32-bit output perf_conflict_cycles, counting cycles with count != 0 and pipe_eff (head blocked), and a 32-bit output perf_stall_cycles, counting cycles with pipe_stall high. Both wrap at 2^32 and reset to 0 on rst_n.
- Undefined: neither port nor the counter logic exists.

Test Plan:
- Reset, then pipe writes rd=5 data=0xAA with the FIFO empty -> rf_reg_write=1, rf_rd=5, rf_data=0xAA same cycle; mdu_ready=1, fifo_count=0.
- MDU writes rd=7 data=0x1234 while the pipeline is idle -> fifo_count=1 next cycle, and rf_rd=7 rf_data=0x1234 written that cycle. q_ra1=7 gives q_hit1=1 while buffered and 0 after the drain.
- DEPTH=2, pipeline writes every cycle, MDU pushes 3 results -> mdu_ready=0 after 2 accepts. pipe_stall rises after MAX_WAIT=4 blocked cycles. During the stall the head drains, and a pipe write to rd=3 is not performed.
- MDU result with rd=0 -> handshake completes, fifo_count stays 0, no rf write. A pipe write to rd=0 gives rf_reg_write=0.
- FIFO full, pop and MDU valid in the same cycle -> no accept (mdu_ready=0). Next cycle ready=1, the accept occurs, and the write pointer wraps correctly; entries drain in FIFO order.
- Assert rst_n low with 2 entries buffered and pipe_stall=1 -> all outputs 0 immediately; after release fifo_count=0 and no stale writes appear.
